// File: rtl/mod12_monitor.sv
// Passive checker for a mod-12 up/down counter: keeps a reference model of the
// observed counter, flags mismatches and illegal values, and counts wraps.
module mod12_monitor #(
    parameter int unsigned ERR_W       = 8,
    parameter int unsigned WRAP_W      = 8,
    parameter bit          AUTO_RESYNC = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              clr_stats,
    input  logic              obs_load,
    input  logic              obs_mode,
    input  logic [3:0]        obs_data_in,
    input  logic [3:0]        obs_count,
    output logic              synced,
    output logic [3:0]        expected,
    output logic              mismatch,
    output logic              illegal,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_up_cnt,
    output logic [WRAP_W-1:0] wrap_dn_cnt
);

    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(11);

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        TRACK  = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   expected_nxt;
    logic               mismatch_nxt;
    logic               illegal_nxt;
    logic               sticky_nxt;
    logic [ERR_W-1:0]   err_nxt;
    logic [WRAP_W-1:0]  wrap_up_nxt;
    logic [WRAP_W-1:0]  wrap_dn_nxt;

    logic               illegal_ld;
    logic               illegal_cnt;
    logic               hit;
    logic [CNT_W-1:0]   predicted;

    // Next value of the observed counter given its current inputs and count.
    function automatic logic [CNT_W-1:0] next_count(
        input logic             ld,
        input logic             md,
        input logic [CNT_W-1:0] d,
        input logic [CNT_W-1:0] c
    );
        if (ld)
            return d;
        else if (md)
            return (c == MAX_CNT) ? CNT_W'(0) : c + CNT_W'(1);
        else
            return (c == CNT_W'(0)) ? MAX_CNT : c - CNT_W'(1);
    endfunction

    assign illegal_ld  = obs_load && (obs_data_in > MAX_CNT);
    assign illegal_cnt = obs_count > MAX_CNT;
    assign hit         = obs_count == expected;
    assign predicted   = next_count(obs_load, obs_mode, obs_data_in, obs_count);

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        expected_nxt = expected;
        mismatch_nxt = 1'b0;
        illegal_nxt  = 1'b0;
        sticky_nxt   = err_sticky;
        err_nxt      = err_count;
        wrap_up_nxt  = wrap_up_cnt;
        wrap_dn_nxt  = wrap_dn_cnt;

        if (!en) begin
            state_nxt = UNSYNC;
        end else begin
            unique case (state)
                UNSYNC: begin
                    if (illegal_ld || illegal_cnt) begin
                        illegal_nxt = 1'b1;
                        sticky_nxt  = 1'b1;
                    end else begin
                        expected_nxt = predicted;
                        state_nxt    = TRACK;
                    end
                end
                TRACK: begin
                    if (!hit) begin
                        mismatch_nxt = 1'b1;
                        sticky_nxt   = 1'b1;
                        if (err_count != '1)
                            err_nxt = err_count + ERR_W'(1);
                    end
                    if (illegal_ld || illegal_cnt) begin
                        // Model cannot follow an out-of-range value; start over.
                        illegal_nxt = 1'b1;
                        sticky_nxt  = 1'b1;
                        state_nxt   = UNSYNC;
                    end else if (hit || AUTO_RESYNC) begin
                        expected_nxt = predicted;
                        if (!obs_load && obs_mode && (obs_count == MAX_CNT)
                                && (wrap_up_cnt != '1))
                            wrap_up_nxt = wrap_up_cnt + WRAP_W'(1);
                        if (!obs_load && !obs_mode && (obs_count == CNT_W'(0))
                                && (wrap_dn_cnt != '1))
                            wrap_dn_nxt = wrap_dn_cnt + WRAP_W'(1);
                    end else begin
                        state_nxt = FAULT;
                    end
                end
                FAULT: begin
                    state_nxt = FAULT;
                end
                default: begin
                    state_nxt = UNSYNC;
                end
            endcase
        end

        // Clear overrides any statistic update on the same edge; pulses survive.
        if (clr_stats) begin
            sticky_nxt  = 1'b0;
            err_nxt     = '0;
            wrap_up_nxt = '0;
            wrap_dn_nxt = '0;
            if (state_nxt == FAULT)
                state_nxt = UNSYNC;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= UNSYNC;
            synced      <= 1'b0;
            expected    <= '0;
            mismatch    <= 1'b0;
            illegal     <= 1'b0;
            err_sticky  <= 1'b0;
            err_count   <= '0;
            wrap_up_cnt <= '0;
            wrap_dn_cnt <= '0;
        end else begin
            state       <= state_nxt;
            synced      <= state_nxt == TRACK;
            expected    <= expected_nxt;
            mismatch    <= mismatch_nxt;
            illegal     <= illegal_nxt;
            err_sticky  <= sticky_nxt;
            err_count   <= err_nxt;
            wrap_up_cnt <= wrap_up_nxt;
            wrap_dn_cnt <= wrap_dn_nxt;
        end
    end

endmodule

// File: doc/mod12_monitor.md
Name: mod12_monitor

Overview:
Passive observer and checker for the output end of the mod-12 up/down counter interface. It samples the counter's load, mode, data_in and count_out, keeps its own reference model, and flags any cycle where count_out differs from the predicted value. It also counts up-wraps and down-wraps and keeps saturating error statistics. It sits beside the counter in the system and in benches, and drives nothing back into the counter.

Parameters:
ERR_W, 8, width of the saturating mismatch counter
WRAP_W, 8, width of each saturating wrap counter
AUTO_RESYNC, 1, 1 = after a mismatch, realign the model to the observed count and keep tracking; 0 = enter FAULT and hold until clr_stats

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  monitor enable
clr_stats  input  1  synchronous clear of statistics and FAULT
obs_load  input  1  observed counter load
obs_mode  input  1  observed counter mode (1 = up, 0 = down)
obs_data_in  input  4  observed counter load value
obs_count  input  4  observed counter count_out
synced  output  1  high in TRACK
expected  output  4  model's predicted count for the current cycle
mismatch  output  1  one-cycle pulse on a compare failure
illegal  output  1  one-cycle pulse on a loaded data_in > 11 or an observed count > 11
err_sticky  output  1  set on any mismatch or illegal event; cleared only by reset or clr_stats
err_count  output  ERR_W  saturating mismatch count
wrap_up_cnt  output  WRAP_W  saturating count of 11->0 up transitions
wrap_dn_cnt  output  WRAP_W  saturating count of 0->11 down transitions

Behaviour:
- Reset value of every output while reset = 0 (asynchronous): all outputs 0; state = UNSYNC.
- Next-count function f(load, mode, d, c):
  - load = 1: returns d (load has priority over mode).
  - load = 0, mode = 1: returns (c == 11) ? 0 : c + 1.
  - load = 0, mode = 0: returns (c == 0) ? 11 : c - 1.
- States: UNSYNC, TRACK, FAULT.
- UNSYNC, on a rising edge with en = 1:
  - obs_count <= 11: expected <= f(obs_load, obs_mode, obs_data_in, obs_count); go to TRACK.
  - obs_count > 11: pulse illegal; stay in UNSYNC.
- TRACK, on each rising edge: compare obs_count with the registered expected.
  - Equal: expected <= f(inputs, obs_count).
  - Different: pulse mismatch; err_count += 1 (saturating); set err_sticky.
    - AUTO_RESYNC = 1: expected <= f(inputs, obs_count); stay in TRACK.
    - AUTO_RESYNC = 0: go to FAULT; expected holds.
- Compare latency: counter inputs at edge n are checked against obs_count at edge n+1. mismatch is registered, so it is visible in the cycle after edge n+1.
- Illegal load: obs_load = 1 with obs_data_in > 11, seen in TRACK or UNSYNC with en = 1.
  - Pulse illegal and set err_sticky.
  - Go to UNSYNC; no compare is made on the following edge.
- Wrap counting (TRACK only, on the same edge that updates expected, obs_load = 0):
  - mode = 1 and source count 11: wrap_up_cnt += 1.
  - mode = 0 and source count 0: wrap_dn_cnt += 1.
  - A load never counts as a wrap.
- FAULT: no compares, no wraps; synced = 0. Exit only via clr_stats (to UNSYNC), reset, or en = 0.
- en = 0: go to UNSYNC on the next edge; statistics and err_sticky hold; no pulses.
- clr_stats = 1:
  - Zeroes err_count, wrap_up_cnt, wrap_dn_cnt and err_sticky.
  - FAULT -> UNSYNC.
  - If a mismatch or illegal event occurs on the same edge, the clear wins for all statistics, but the pulse output still asserts.
- Saturation: counters stop at all-ones and never roll over.
- Reset mid-operation: immediate return to reset values; resync on the first enabled edge after release.

Test Plan:
1. Reset release, en = 1; counter loaded with 2 and mode = 1, producing 2,3,...,11,0,1 -> synced = 1 after the first edge; no mismatch; wrap_up_cnt = 1; err_count = 0.
2. mode = 0 from 1: observed 1,0,11,10 -> wrap_dn_cnt = 1; expected tracks each value; no mismatch.
3. Injected fault: obs_count forced to 7 when expected = 5, AUTO_RESYNC = 1 -> single mismatch pulse; err_count = 1; err_sticky = 1; tracking continues from 7 -> 8 with no further errors.
4. Same fault with AUTO_RESYNC = 0 -> FAULT and synced = 0; then clr_stats pulse -> err_count = 0, err_sticky = 0, UNSYNC, resync next edge.
5. obs_load = 1 with obs_data_in = 10 (0b1010) vs 13 (0b1101) -> 10: expected = 10, no error; 13: illegal pulse, UNSYNC, err_count unchanged.
6. Inject 300 mismatches with ERR_W = 8 -> err_count saturates at 255. Then assert reset low mid-count -> all outputs 0 immediately, before the next clock edge.
